// File: rtl/dm_access_unit.sv
// ---------------------------------------------------------------------------
// dm_access_unit
//
// Data-memory access stage sitting between the core's MEM-stage port and a
// handshaked, word-wide data RAM / MIO bus. Byte, half and word loads/stores
// are turned into byte-enabled word accesses, and load data is sign- or
// zero-extended before it is returned to the core. The core is stalled via
// cpu_ready while an access is in flight. Misaligned accesses never reach the
// bus. Accesses that are not acknowledged within TIMEOUT_CYC request cycles
// complete with an error.
//
// Parameters:
//   TIMEOUT_CYC  request cycles without mem_ack before error completion (1..255)
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   cpu_we       store request
//   cpu_re       load request (cpu_we wins if both are high)
//   cpu_addr     byte address
//   cpu_wdata    right-aligned store data
//   cpu_dm_ctrl  000 word, 001 half, 010 half-unsigned, 011 byte,
//                100 byte-unsigned, 101..111 word
//   cpu_rdata    extended load data, valid while cpu_ready is high in DONE
//   cpu_ready    0 stalls the core
//   cpu_err      1 in DONE if the access was misaligned or timed out
//   mem_req      registered bus request
//   mem_we       registered bus write strobe
//   mem_addr     registered word address (cpu_addr[31:2])
//   mem_be       registered byte enables
//   mem_wdata    registered, lane-replicated store data
//   mem_rdata    bus read data, sampled when mem_ack is high
//   mem_ack      one-cycle bus completion
// ---------------------------------------------------------------------------
module dm_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_dm_ctrl,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_t;

    typedef enum logic [1:0] {
        SzWord,
        SzHalf,
        SzByte
    } size_t;

    state_t      state;
    logic [7:0]  tmo_cnt;

    // Attributes of the access in flight, needed to extract the load result.
    logic [1:0]  off_q;
    size_t       size_q;
    logic        uns_q;
    logic        we_q;

    // Request decode from the core side.
    logic        cpu_req;
    size_t       req_size;
    logic        req_uns;
    logic        misaligned;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;

    // Load extraction from the bus side.
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    logic [8:0]  tmo_next;
    logic        tmo_hit;

    assign cpu_req = cpu_we | cpu_re;

    always_comb begin
        req_size = SzWord;
        req_uns  = 1'b0;
        unique case (cpu_dm_ctrl)
            3'b001: req_size = SzHalf;
            3'b010: begin
                req_size = SzHalf;
                req_uns  = 1'b1;
            end
            3'b011: req_size = SzByte;
            3'b100: begin
                req_size = SzByte;
                req_uns  = 1'b1;
            end
            default: req_size = SzWord;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            SzHalf:  misaligned = cpu_addr[0];
            SzWord:  misaligned = |cpu_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Store data is replicated into every lane so the bus only needs the enables.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = cpu_wdata;
        unique case (req_size)
            SzByte: begin
                store_be    = 4'b0001 << cpu_addr[1:0];
                store_wdata = {4{cpu_wdata[7:0]}};
            end
            SzHalf: begin
                store_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{cpu_wdata[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = cpu_wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata[7:0];
        unique case (off_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_ext = mem_rdata;
        unique case (size_q)
            SzByte:  load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SzHalf:  load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // tmo_next counts the current REQ cycle; reaching the limit ends the access.
    assign tmo_next = {1'b0, tmo_cnt} + 9'd1;
    assign tmo_hit  = tmo_next >= 9'(TIMEOUT_CYC);

    assign cpu_ready = ((state == StIdle) & ~cpu_req) | (state == StDone);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            tmo_cnt   <= 8'd0;
            off_q     <= 2'd0;
            size_q    <= SzWord;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            cpu_rdata <= 32'd0;
            cpu_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cpu_req) begin
                        if (misaligned) begin
                            cpu_err   <= 1'b1;
                            cpu_rdata <= 32'd0;
                            state     <= StDone;
                        end else begin
                            off_q     <= cpu_addr[1:0];
                            size_q    <= req_size;
                            uns_q     <= req_uns;
                            we_q      <= cpu_we;
                            tmo_cnt   <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr[31:2];
                            mem_be    <= store_be;
                            mem_wdata <= store_wdata;
                            state     <= StReq;
                        end
                    end
                end
                StReq: begin
                    // An ack in the same cycle as the timeout still completes cleanly.
                    if (mem_ack) begin
                        cpu_rdata <= we_q ? 32'd0 : load_ext;
                        cpu_err   <= 1'b0;
                        mem_req   <= 1'b0;
                        state     <= StDone;
                    end else if (tmo_hit) begin
                        cpu_rdata <= 32'd0;
                        cpu_err   <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= StDone;
                    end else begin
                        tmo_cnt <= tmo_next[7:0];
                    end
                end
                StDone: begin
                    tmo_cnt <= 8'd0;
                    state   <= StIdle;
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_dm_ctrl;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_run  = 0;
    int n_fail = 0;

    dm_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_dm_ctrl(cpu_dm_ctrl),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .cpu_err    (cpu_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: access size in bytes, lane offset, arithmetic extension.
    task automatic model(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         output logic [3:0] be, output logic [31:0] wdata,
                         output logic [31:0] rdata, output logic mis);
        int unsigned       nbytes;
        int unsigned       off;
        bit                uns;
        longint unsigned   mask;
        longint unsigned   v;
        off = addr % 4;
        case (ctrl)
            3'd1, 3'd2: nbytes = 2;
            3'd3, 3'd4: nbytes = 1;
            default:    nbytes = 4;
        endcase
        uns  = (ctrl == 3'd2) || (ctrl == 3'd4);
        mis  = (addr % nbytes) != 0;
        mask = (64'd1 << (8 * nbytes)) - 1;
        be   = 4'(((1 << nbytes) - 1) << off);
        v    = longint'(wd) & mask;
        if (nbytes == 1)      wdata = 32'(v * 64'h01010101);
        else if (nbytes == 2) wdata = 32'(v * 64'h00010001);
        else                  wdata = wd;
        v = (longint'(rd) >> (8 * off)) & mask;
        if (!uns && nbytes < 4 && v >= (mask + 1) / 2)
            v = v + 64'h1_0000_0000 - (mask + 1);
        rdata = we ? 32'd0 : 32'(v);
    endtask

    // Drives one access from an IDLE cycle (entered at posedge+1) and observes
    // it. ack_at is the REQ cycle number carrying mem_ack (0: never).
    task automatic run_access(input logic we, input logic re, input logic [2:0] ctrl,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at,
                              output int done_cyc, output int req_cnt,
                              output logic [31:0] got_rdata, output logic got_err,
                              output logic [3:0] got_be, output logic [31:0] got_wdata,
                              output logic [29:0] got_addr, output logic got_we,
                              output bit stable, output logic ready0);
        int cyc;
        cpu_we      = we;
        cpu_re      = re;
        cpu_addr    = addr;
        cpu_wdata   = wd;
        cpu_dm_ctrl = ctrl;
        done_cyc    = -1;
        req_cnt     = 0;
        stable      = 1'b1;
        got_rdata   = '0;
        got_err     = 1'b0;
        got_be      = '0;
        got_wdata   = '0;
        got_addr    = '0;
        got_we      = 1'b0;
        #1;
        ready0 = cpu_ready;
        cyc = 0;
        while (cyc < 40) begin
            if (cyc > 0 && cpu_ready) begin
                done_cyc  = cyc;
                got_rdata = cpu_rdata;
                got_err   = cpu_err;
                @(posedge clk);
                #1;
                cpu_we = 1'b0;
                cpu_re = 1'b0;
                break;
            end
            if (mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    got_be    = mem_be;
                    got_wdata = mem_wdata;
                    got_addr  = mem_addr;
                    got_we    = mem_we;
                end else if (mem_be !== got_be || mem_wdata !== got_wdata ||
                             mem_addr !== got_addr || mem_we !== got_we) begin
                    stable = 1'b0;
                end
                if (req_cnt == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            cyc++;
        end
        if (done_cyc < 0) begin
            cpu_we = 1'b0;
            cpu_re = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_run++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, cpu_rdata, cpu_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h rd=%h err=%b, need all 0",
                     mem_req, mem_we, mem_addr, mem_be, mem_wdata, cpu_rdata, cpu_err);
        end
        n_run++;
        if (cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b need 1", cpu_ready);
        end
    endtask

    task automatic test_store_byte();
        int d, r; logic [31:0] rdv, wdv; logic e, w, r0; logic [3:0] be; logic [29:0] a; bit st;
        run_access(1'b1, 1'b0, 3'b011, 32'h0000_1013, 32'h0000_00A5, 32'h0, 1,
                   d, r, rdv, e, be, wdv, a, w, st, r0);
        n_run++;
        if (be !== 4'b1000 || wdv !== 32'hA5A5_A5A5 || w !== 1'b1 || a !== 30'h404) begin
            n_fail++;
            $display("FAIL sb_bus: got be=%b wd=%h we=%b a=%h need 1000 A5A5A5A5 1 404",
                     be, wdv, w, a);
        end
        n_run++;
        if (d !== 2 || e !== 1'b0 || r0 !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_timing: got done=%0d err=%b ready0=%b need 2 0 0", d, e, r0);
        end
    endtask

    task automatic test_load_extract();
        logic [2:0]  ctrls [5];
        logic [31:0] addrs [5];
        logic [31:0] exps  [5];
        int d, r; logic [31:0] rdv, wdv; logic e, w, r0; logic [3:0] be; logic [29:0] a; bit st;
        ctrls = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b000};
        addrs = '{32'h0000_2002, 32'h0000_2002, 32'h0000_2002, 32'h0000_2002, 32'h0000_2000};
        exps  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280, 32'h0000_1280, 32'h1280_FF34};
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, 1'b1, ctrls[i], addrs[i], 32'h0, 32'h1280_FF34, 1,
                       d, r, rdv, e, be, wdv, a, w, st, r0);
            n_run++;
            if (rdv !== exps[i] || e !== 1'b0 || d !== 2) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: got rdata=%h err=%b done=%0d need %h 0 2",
                         i, rdv, e, d, exps[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        int d, r; logic [31:0] rdv, wdv; logic e, w, r0; logic [3:0] be; logic [29:0] a; bit st;
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0, 32'hFFFF_FFFF, 1,
                   d, r, rdv, e, be, wdv, a, w, st, r0);
        n_run++;
        if (r !== 0 || d !== 1 || e !== 1'b1 || rdv !== 32'h0) begin
            n_fail++;
            $display("FAIL misaligned_lw: got req_cycles=%0d done=%0d err=%b rdata=%h need 0 1 1 0",
                     r, d, e, rdv);
        end
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_3003, 32'h1234, 32'h0, 1,
                   d, r, rdv, e, be, wdv, a, w, st, r0);
        n_run++;
        if (r !== 0 || d !== 1 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_sh: got req_cycles=%0d done=%0d err=%b need 0 1 1", r, d, e);
        end
    endtask

    task automatic test_timeout();
        int d, r; logic [31:0] rdv, wdv; logic e, w, r0; logic [3:0] be; logic [29:0] a; bit st;
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_4000, 32'h0, 32'h5555_AAAA, 0,
                   d, r, rdv, e, be, wdv, a, w, st, r0);
        n_run++;
        if (r !== 4 || d !== 5 || e !== 1'b1 || rdv !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout: got req_cycles=%0d done=%0d err=%b rdata=%h need 4 5 1 0",
                     r, d, e, rdv);
        end
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_4000, 32'h0, 32'h5555_AAAA, 4,
                   d, r, rdv, e, be, wdv, a, w, st, r0);
        n_run++;
        if (r !== 4 || d !== 5 || e !== 1'b0 || rdv !== 32'h5555_AAAA) begin
            n_fail++;
            $display("FAIL ack_wins: got req_cycles=%0d done=%0d err=%b rdata=%h need 4 5 0 5555aaaa",
                     r, d, e, rdv);
        end
    endtask

    task automatic test_back_to_back();
        int d, r; logic [31:0] rdv, wdv; logic e, w, r0; logic [3:0] be; logic [29:0] a; bit st;
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_5100, 32'hCAFE_F00D, 32'h0, 3,
                   d, r, rdv, e, be, wdv, a, w, st, r0);
        n_run++;
        if (r !== 3 || d !== 4 || !st || r0 !== 1'b0 || be !== 4'hF || wdv !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL b2b_sw: got req=%0d done=%0d stable=%b ready0=%b be=%b wd=%h need 3 4 1 0 1111 cafef00d",
                     r, d, st, r0, be, wdv);
        end
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_5100, 32'h0, 32'h8765_4321, 3,
                   d, r, rdv, e, be, wdv, a, w, st, r0);
        n_run++;
        if (r !== 3 || d !== 4 || !st || r0 !== 1'b0 || rdv !== 32'h8765_4321 || w !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_lw: got req=%0d done=%0d stable=%b ready0=%b rdata=%h we=%b need 3 4 1 0 87654321 0",
                     r, d, st, r0, rdv, w);
        end
    endtask

    task automatic test_reset_mid();
        int d, r; logic [31:0] rdv, wdv; logic e, w, r0; logic [3:0] be; logic [29:0] a; bit st;
        cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 32'h0000_6004;
        cpu_wdata = 32'h1111_2222; cpu_dm_ctrl = 3'b000;
        @(posedge clk);
        #1;
        n_run++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_req_started: got %b need 1", mem_req);
        end
        reset = 1'b1; cpu_we = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_run++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, cpu_rdata, cpu_err} !== '0 ||
            cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got req=%b we=%b be=%b wd=%h rd=%h err=%b rdy=%b need zeros, rdy 1",
                     mem_req, mem_we, mem_be, mem_wdata, cpu_rdata, cpu_err, cpu_ready);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        n_run++;
        if (mem_req !== 1'b0 || cpu_rdata !== 32'h0 || cpu_ready !== 1'b1 || cpu_err !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack: got req=%b rdata=%h rdy=%b err=%b need 0 0 1 0",
                     mem_req, cpu_rdata, cpu_ready, cpu_err);
        end
        run_access(1'b0, 1'b1, 3'b100, 32'h0000_6007, 32'h0, 32'h9A00_0000, 2,
                   d, r, rdv, e, be, wdv, a, w, st, r0);
        n_run++;
        if (d !== 3 || e !== 1'b0 || rdv !== 32'h0000_009A) begin
            n_fail++;
            $display("FAIL after_reset: got done=%0d err=%b rdata=%h need 3 0 0000009a", d, e, rdv);
        end
    endtask

    task automatic test_random();
        int d, r; logic [31:0] rdv, wdv; logic e, w, r0; logic [3:0] be; logic [29:0] a; bit st;
        logic [3:0] xbe; logic [31:0] xwd, xrd; logic xmis;
        logic we, re; logic [2:0] ctrl; logic [31:0] addr, wd, rd; int ack_at;
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom_range(0, 1));
            re   = we ? 1'($urandom_range(0, 1)) : 1'b1;
            ctrl = 3'($urandom_range(0, 7));
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            ack_at = (i % 8 == 7) ? 0 : $urandom_range(1, 5);
            model(we, ctrl, addr, wd, rd, xbe, xwd, xrd, xmis);
            run_access(we, re, ctrl, addr, wd, rd, ack_at, d, r, rdv, e, be, wdv, a, w, st, r0);
            n_run++;
            if (xmis) begin
                if (r !== 0 || d !== 1 || e !== 1'b1 || rdv !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rnd_mis[%0d]: got req=%0d done=%0d err=%b rdata=%h need 0 1 1 0",
                             i, r, d, e, rdv);
                end
            end else if (ack_at >= 1 && ack_at <= int'(TO)) begin
                if (r !== ack_at || d !== ack_at + 1 || e !== 1'b0 || rdv !== xrd) begin
                    n_fail++;
                    $display("FAIL rnd_ok[%0d]: got req=%0d done=%0d err=%b rdata=%h need %0d %0d 0 %h",
                             i, r, d, e, rdv, ack_at, ack_at + 1, xrd);
                end
            end else begin
                if (r !== int'(TO) || d !== int'(TO) + 1 || e !== 1'b1 || rdv !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rnd_tmo[%0d]: got req=%0d done=%0d err=%b rdata=%h need %0d %0d 1 0",
                             i, r, d, e, rdv, TO, TO + 1);
                end
            end
            if (!xmis) begin
                n_run++;
                if (be !== xbe || wdv !== xwd || a !== addr[31:2] || w !== we || !st) begin
                    n_fail++;
                    $display("FAIL rnd_bus[%0d]: got be=%b wd=%h a=%h we=%b stable=%b need %b %h %h %b 1",
                             i, be, wdv, a, w, st, xbe, xwd, addr[31:2], we);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        cpu_we      = 1'b0;
        cpu_re      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        cpu_dm_ctrl = '0;
        mem_rdata   = '0;
        mem_ack     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_store_byte();
        test_load_extract();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
